// File: rtl/fusion_pkg.sv
// fusion_pkg: shared types and helpers for the sequential two-track fusion engine.
//   fus_state_t  - engine FSM states
//   div_cycles() - divider iterations per element (one quotient bit per cycle, 2*W bits)
//   gain_half()  - unsigned Q1.(W-1) encoding of 0.5, used for the gain of invalid elements
package fusion_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    STORE,
    DONE
  } fus_state_t;

  function automatic int div_cycles(input int w);
    return 2 * w;
  endfunction

  function automatic int gain_half(input int w);
    return 1 << (w - 2);
  endfunction

endpackage

// File: rtl/fusion_divider.sv
// fusion_divider: unsigned restoring divider, one quotient bit per clock.
//   clk, rst  - clock, synchronous active-high reset
//   start     - load num/den and begin; takes NUM_W cycles
//   num, den  - dividend (NUM_W bits) and divisor (DEN_W bits, must be non-zero)
//   busy      - iterations remaining
//   done      - high during the cycle whose edge produces the final quotient bit
//   quo       - low QUO_W bits of the quotient (valid once busy drops)
module fusion_divider #(
  parameter int NUM_W = 32,
  parameter int DEN_W = 17,
  parameter int QUO_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quo
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  // Holds the dividend initially; quotient bits shift in from the right as
  // dividend bits shift out of the top into the partial remainder.
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   diff;

  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    den_d = den_q;
    quo_d = quo_q;
    trial = {rem_q, quo_q[NUM_W-1]};
    diff  = trial - {1'b0, den_q};
    if (start) begin
      cnt_d = CNT_W'(NUM_W);
      rem_d = '0;
      den_d = den;
      quo_d = num;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (trial >= {1'b0, den_q}) begin
        rem_d = diff[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      quo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      den_q <= den_d;
      quo_q <= quo_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CNT_W'(1));
  assign quo  = quo_q[QUO_W-1:0];

endmodule

// File: rtl/fusion_engine_seq.sv
// fusion_engine_seq: sequential two-track state fusion, one element at a time.
//   Xf = (P2*X1 + P1*X2)/(P1+P2), Pf = P1*P2/(P1+P2), quotients truncated toward zero.
//   Elements with P1<0, P2<0 or P1+P2==0 skip the divide: Xf=(X1+X2)>>>1, Pf=0, err=1.
// Ports:
//   clk, rst            - clock, synchronous active-high reset (aborts any operation)
//   in_valid/in_ready   - input handshake; in_ready while idle
//   p1_diag, p2_diag    - covariance diagonals, N_STATES x W signed
//   x1, x2              - track states, N_STATES x W signed
//   out_valid/out_ready - result handshake; results held while out_valid & !out_ready
//   xf                  - fused state, N_STATES x W signed
//   pf                  - fused covariance, N_STATES x 2W signed
//   err                 - per-element invalid-covariance flag
//   gain                - (only with FUSION_GAIN_OUT_EN) K = (P1<<(W-1))/(P1+P2), unsigned Q1.(W-1)
// Build option: define FUSION_GAIN_OUT_EN to add the gain port and its divider.
module fusion_engine_seq
  import fusion_pkg::*;
#(
  parameter int W        = 16,
  parameter int N_STATES = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_STATES*W-1:0]   p1_diag,
  input  logic [N_STATES*W-1:0]   p2_diag,
  input  logic [N_STATES*W-1:0]   x1,
  input  logic [N_STATES*W-1:0]   x2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_STATES*W-1:0]   xf,
  output logic [N_STATES*2*W-1:0] pf,
  output logic [N_STATES-1:0]     err
`ifdef FUSION_GAIN_OUT_EN
  ,
  output logic [N_STATES*W-1:0]   gain
`endif
);

  localparam int W2    = div_cycles(W);
  localparam int IDX_W = (N_STATES > 1) ? $clog2(N_STATES) : 1;

  fus_state_t         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N_STATES*W-1:0] p1_q, p2_q, x1_q, x2_q;
  logic               accept;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;

  // Current element, selected from the captured vectors
  logic signed [W-1:0]  p1_e, p2_e, x1_e, x2_e;
  assign p1_e = p1_q[idx_q*W +: W];
  assign p2_e = p2_q[idx_q*W +: W];
  assign x1_e = x1_q[idx_q*W +: W];
  assign x2_e = x2_q[idx_q*W +: W];

  logic signed [W:0]    den_s;
  logic signed [W2-1:0] prod_x1, prod_x2, num_p;
  logic signed [W2:0]   num_x;
  logic signed [W:0]    sum_x;
  logic [W2-1:0]        num_x_mag;
  logic [W:0]           den_u;
  logic                 elem_bad;
  logic [W-1:0]         quo_x;
  logic [W2-1:0]        quo_p;
  logic [W-1:0]         xf_elem_d;
  logic [W2-1:0]        pf_elem_d;
  logic                 div_start, div_done, div_busy;
  logic                 busy_x, busy_p, done_x, done_p;

  always_comb begin
    den_s     = {p1_e[W-1], p1_e} + {p2_e[W-1], p2_e};
    prod_x1   = W2'(p2_e) * W2'(x1_e);
    prod_x2   = W2'(p1_e) * W2'(x2_e);
    num_p     = W2'(p1_e) * W2'(p2_e);
    num_x     = {prod_x1[W2-1], prod_x1} + {prod_x2[W2-1], prod_x2};
    sum_x     = {x1_e[W-1], x1_e} + {x2_e[W-1], x2_e};
    num_x_mag = num_x[W2] ? W2'(-num_x) : W2'(num_x);
    den_u     = den_s;
    elem_bad  = p1_e[W-1] | p2_e[W-1] | (den_s == '0);
    // Magnitude quotient, then the numerator's sign: truncation toward zero.
    if (elem_bad) begin
      xf_elem_d = W'(sum_x >>> 1);
      pf_elem_d = '0;
    end else begin
      xf_elem_d = num_x[W2] ? (-quo_x) : quo_x;
      pf_elem_d = quo_p;
    end
  end

  assign div_start = (state_q == MUL) && !elem_bad;

  // numP is non-negative for every element that reaches the divider.
  fusion_divider #(.NUM_W(W2), .DEN_W(W + 1), .QUO_W(W)) u_div_x (
    .clk(clk), .rst(rst), .start(div_start), .num(num_x_mag), .den(den_u),
    .busy(busy_x), .done(done_x), .quo(quo_x)
  );

  fusion_divider #(.NUM_W(W2), .DEN_W(W + 1), .QUO_W(W2)) u_div_p (
    .clk(clk), .rst(rst), .start(div_start), .num(W2'(num_p)), .den(den_u),
    .busy(busy_p), .done(done_p), .quo(quo_p)
  );

`ifdef FUSION_GAIN_OUT_EN
  localparam logic [W-1:0] GAIN_HALF = W'(gain_half(W));
  logic [W-1:0] quo_g;
  logic [W-1:0] gain_elem_d;
  logic         busy_g, done_g;

  fusion_divider #(.NUM_W(W2), .DEN_W(W + 1), .QUO_W(W)) u_div_g (
    .clk(clk), .rst(rst), .start(div_start),
    .num({1'b0, p1_e, {(W - 1){1'b0}}}), .den(den_u),
    .busy(busy_g), .done(done_g), .quo(quo_g)
  );

  assign gain_elem_d = elem_bad ? GAIN_HALF : quo_g;
  assign div_done    = done_x & done_p & done_g;
  assign div_busy    = busy_x | busy_p | busy_g;
`else
  assign div_done    = done_x & done_p;
  assign div_busy    = busy_x | busy_p;
`endif

  // Control FSM. The !div_busy exit only guards against a stuck DIV state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q <= MUL;
          idx_q   <= '0;
        end
        MUL:   state_q <= elem_bad ? STORE : DIV;
        DIV:   if (div_done || !div_busy) state_q <= STORE;
        STORE: if (idx_q == IDX_W'(N_STATES - 1)) begin
          state_q <= DONE;
        end else begin
          idx_q   <= idx_q + IDX_W'(1);
          state_q <= MUL;
        end
        DONE: if (out_ready) begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q <= '0;
      p2_q <= '0;
      x1_q <= '0;
      x2_q <= '0;
    end else if (accept) begin
      p1_q <= p1_diag;
      p2_q <= p2_diag;
      x1_q <= x1;
      x2_q <= x2;
    end
  end

  // Per-element result registers, each written only at its own STORE.
  for (genvar gi = 0; gi < N_STATES; gi++) begin : g_elem
    logic          store_en;
    logic [W-1:0]  xf_e_q;
    logic [W2-1:0] pf_e_q;
    logic          err_e_q;

    assign store_en = (state_q == STORE) && (idx_q == IDX_W'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        xf_e_q  <= '0;
        pf_e_q  <= '0;
        err_e_q <= 1'b0;
      end else if (store_en) begin
        xf_e_q  <= xf_elem_d;
        pf_e_q  <= pf_elem_d;
        err_e_q <= elem_bad;
      end
    end

    assign xf[gi*W +: W]   = xf_e_q;
    assign pf[gi*W2 +: W2] = pf_e_q;
    assign err[gi]         = err_e_q;

`ifdef FUSION_GAIN_OUT_EN
    logic [W-1:0] gain_e_q;
    always_ff @(posedge clk) begin
      if (rst)           gain_e_q <= '0;
      else if (store_en) gain_e_q <= gain_elem_d;
    end
    assign gain[gi*W +: W] = gain_e_q;
`endif
  end

endmodule
